buf_pipe: RTL
=============

BUF_PIPE -- requirements
Module: buf_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, meaning data width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, legal range 2..64).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: upstream word.
REQ-008 The block SHALL have port in_ready, output, 1 bit: buffer can accept a word this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: head word present.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: head word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the head word.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries.

Function
REQ-013 Push SHALL occur when in_valid && in_ready at a rising edge; pop SHALL occur when out_valid && out_ready at a rising edge.
REQ-014 Storage SHALL be first-in first-out; words SHALL leave in acceptance order, with no loss or duplication.
REQ-015 in_ready SHALL equal (count != DEPTH), driven from registered state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (count != 0), driven from registered state only, with no combinational path from in_valid.
REQ-017 out_data SHALL show the head entry whenever out_valid=1, and SHALL be all-zeros whenever out_valid=0.
REQ-018 Latency SHALL be 1 cycle: a word pushed at edge N into an empty buffer SHALL appear with out_valid=1 after edge N; same-cycle pass-through is not provided.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-020 A simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 When full, in_ready=0, so no push SHALL occur; a pop in that cycle SHALL reduce count to DEPTH-1.
REQ-022 When empty, out_valid=0, so no pop SHALL occur; a push in that cycle SHALL raise count to 1.
REQ-023 count SHALL update as count + push - pop each cycle and SHALL never exceed DEPTH or underflow.
REQ-024 flush=1 at an edge SHALL set count and both pointers to 0; any push or pop in that cycle SHALL be discarded.
REQ-025 Storage array contents SHALL NOT be reset or cleared; only pointers and count are state with defined reset values.

Reset
REQ-026 reset=1 at an edge SHALL set count=0, both pointers=0, out_valid=0, out_data=0 and in_ready=1 from the following cycle.
REQ-027 reset SHALL have priority over flush, push and pop; reset asserted mid-stream SHALL discard all stored words.
REQ-028 Before the first reset edge, output values are undefined; verification SHALL NOT check them.

Verification
REQ-029 Reset then idle, WIDTH=8, DEPTH=4 -> count=0, out_valid=0, in_ready=1, out_data=0x00.
REQ-030 Push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=0 -> count=4, in_ready=0; a fifth in_valid=1 with 0x55 is not accepted; then out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44 in order, then out_valid=0.
REQ-031 With count=2, hold in_valid=1 and out_ready=1 for 10 cycles with incrementing data -> count stays 2, pointers wrap at least twice, output order is preserved.
REQ-032 Hold in_valid=1 and out_ready=1 continuously from empty -> first out_valid one cycle after the first push, then one word per cycle, with count between 0 and 1.
REQ-033 With count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and neither word is stored or popped.
REQ-034 Random in_valid/out_ready traffic for 10k cycles at DEPTH=2 and DEPTH=64, with reset pulsed mid-run -> output matches a reference queue model, with no overflow or underflow.

Source files
------------

// File: rtl/buf_pipe.sv
// buf_pipe: DEPTH-entry FIFO; a pushed word appears at the head one cycle after the push edge.
// Backpressure: in_ready drops at full and out_valid drops at empty, both from registered count only.
module buf_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  // Handshake flags depend on count alone, so neither ready nor valid sees the other side.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is never cleared; validity is tracked purely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= in_data;
  end

endmodule
